// File: rtl/clkdiv_bank_if.sv
// -----------------------------------------------------------------------------
// clkdiv_bank_if
// Control/status bundle for the clkdiv_bank divider bank.
//   en      : per-channel run enable
//   mode    : per-channel mode, 0 = square toggle, 1 = single-cycle tick
//   sync    : global phase-align restart strobe
//   wr_en   : reload register write strobe
//   wr_ch   : channel index for write and read-back
//   wr_data : reload value to write
//   rd_data : read-back of reload register wr_ch (0 for a non-existent channel)
//   clk_out : per-channel square outputs
//   tick    : per-channel single-cycle enable pulses
// master = controller side, slave = divider bank side.
// -----------------------------------------------------------------------------
interface clkdiv_bank_if #(
    parameter int CH = 4,
    parameter int CW = 28
);
    logic [CH-1:0] en;
    logic [CH-1:0] mode;
    logic          sync;
    logic          wr_en;
    logic [3:0]    wr_ch;
    logic [CW-1:0] wr_data;
    logic [CW-1:0] rd_data;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;

    modport master (
        output en, mode, sync, wr_en, wr_ch, wr_data,
        input  rd_data, clk_out, tick
    );

    modport slave (
        input  en, mode, sync, wr_en, wr_ch, wr_data,
        output rd_data, clk_out, tick
    );
endinterface

// File: rtl/clkdiv_bank.sv
// -----------------------------------------------------------------------------
// clkdiv_bank
// Bank of CH independent programmable dividers / tick generators.
// Each channel counts its reload value down to zero; reaching zero is an
// "event" that reloads the counter and either toggles clk_out (mode 0) or
// raises tick for one cycle (mode 1). Events repeat every reload+1 cycles.
//   clk : system clock, all logic on rising edge
//   rst : asynchronous active-high reset
//   bus : clkdiv_bank_if slave modport (enables, modes, sync, reload
//         write/read port, clk_out and tick outputs)
// -----------------------------------------------------------------------------
module clkdiv_bank #(
    parameter int CH     = 4,
    parameter int CW     = 28,
    parameter int CLK_HZ = 50000000,
    parameter int DEF_HZ = 2
) (
    input  logic          clk,
    input  logic          rst,
    clkdiv_bank_if.slave  bus
);

    localparam logic [CW-1:0] DEF_RELOAD = CW'(CLK_HZ / (2 * DEF_HZ) - 1);

    logic [CW-1:0] reload_q [CH];
    logic [CW-1:0] reload_d [CH];
    logic [CW-1:0] cnt_q    [CH];
    logic [CW-1:0] cnt_d    [CH];
    logic [CH-1:0] clk_out_q, clk_out_d;
    logic [CH-1:0] tick_q, tick_d;
    logic [CH-1:0] wr_hit;

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            // Full 4-bit compare so indices >= CH never alias onto a channel.
            wr_hit[c]    = bus.wr_en && (bus.wr_ch == 4'(c));
            reload_d[c]  = wr_hit[c] ? bus.wr_data : reload_q[c];
            cnt_d[c]     = cnt_q[c];
            clk_out_d[c] = clk_out_q[c];
            tick_d[c]    = 1'b0;

            if (bus.sync) begin
                // Restart overrides everything; a same-edge write is bypassed
                // straight into the counter so the new period starts at once.
                cnt_d[c]     = wr_hit[c] ? bus.wr_data : reload_q[c];
                clk_out_d[c] = 1'b0;
            end else if (bus.en[c]) begin
                if (cnt_q[c] == '0) begin
                    // Reload from the register value before any same-edge write.
                    cnt_d[c] = reload_q[c];
                    if (bus.mode[c]) begin
                        tick_d[c] = 1'b1;
                    end else begin
                        clk_out_d[c] = ~clk_out_q[c];
                    end
                end else begin
                    cnt_d[c] = cnt_q[c] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                reload_q[c] <= DEF_RELOAD;
                cnt_q[c]    <= DEF_RELOAD;
            end
            clk_out_q <= '0;
            tick_q    <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                reload_q[c] <= reload_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        bus.rd_data = '0;
        for (int c = 0; c < CH; c++) begin
            if (bus.wr_ch == 4'(c)) begin
                bus.rd_data = reload_q[c];
            end
        end
    end

    assign bus.clk_out = clk_out_q;
    assign bus.tick    = tick_q;

endmodule

// File: tb/tb_clkdiv_bank.sv
// -----------------------------------------------------------------------------
// tb_clkdiv_bank
// Directed scenarios plus a randomized phase for clkdiv_bank. A scaled-down
// instance (CLK_HZ=1000 -> default reload 249) is exercised cycle by cycle
// against a count-up period model; a default-parameter instance is used only
// for reset read-back of the full-size reload value.
// -----------------------------------------------------------------------------
module tb_clkdiv_bank;

    localparam int CH     = 4;
    localparam int CW     = 28;
    localparam int CLK_HZ = 1000;
    localparam int DEF_HZ = 2;
    localparam int DEF    = CLK_HZ / (2 * DEF_HZ) - 1;      // 249
    localparam int DEF_BIG = 50000000 / (2 * 2) - 1;        // 12,499,999

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clkdiv_bank_if #(.CH(CH), .CW(CW)) b ();
    clkdiv_bank_if #(.CH(4), .CW(28))  bd ();

    clkdiv_bank #(.CH(CH), .CW(CW), .CLK_HZ(CLK_HZ), .DEF_HZ(DEF_HZ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    clkdiv_bank dut_def (
        .clk (clk),
        .rst (rst),
        .bus (bd.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: each channel counts enabled cycles since its last load; the
    // event fires on the cycle after `period` cycles have elapsed.
    int            m_reload [CH];
    int            m_period [CH];
    int            m_elapsed[CH];
    logic [CH-1:0] m_clk;
    logic [CH-1:0] m_tick;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_reload[c]  = DEF;
            m_period[c]  = DEF;
            m_elapsed[c] = 0;
        end
        m_clk  = '0;
        m_tick = '0;
    endtask

    task automatic model_step();
        bit hit;
        for (int c = 0; c < CH; c++) begin
            hit = b.wr_en && (int'(b.wr_ch) == c);
            if (b.sync) begin
                m_period[c]  = hit ? int'(b.wr_data) : m_reload[c];
                m_elapsed[c] = 0;
                m_clk[c]     = 1'b0;
                m_tick[c]    = 1'b0;
            end else if (b.en[c]) begin
                if (m_elapsed[c] == m_period[c]) begin
                    m_period[c]  = m_reload[c];
                    m_elapsed[c] = 0;
                    m_tick[c]    = b.mode[c];
                    if (!b.mode[c]) m_clk[c] = ~m_clk[c];
                end else begin
                    m_elapsed[c]++;
                    m_tick[c] = 1'b0;
                end
            end else begin
                m_tick[c] = 1'b0;
            end
            if (hit) m_reload[c] = int'(b.wr_data);
        end
    endtask

    // One clock edge: advance the model with the inputs present at the edge,
    // then compare all outputs shortly after the edge.
    task automatic cyc();
        int exp_rd;
        @(posedge clk);
        model_step();
        #1;
        exp_rd = (int'(b.wr_ch) < CH) ? m_reload[int'(b.wr_ch)] : 0;
        chk("clk_out", 64'(b.clk_out), 64'(m_clk));
        chk("tick",    64'(b.tick),    64'(m_tick));
        chk("rd_data", 64'(b.rd_data), 64'(exp_rd));
    endtask

    task automatic wr(input int ch, input int val);
        b.wr_en   = 1'b1;
        b.wr_ch   = 4'(ch);
        b.wr_data = CW'(val);
        cyc();
        b.wr_en   = 1'b0;
    endtask

    task automatic do_sync();
        b.sync = 1'b1;
        cyc();
        b.sync = 1'b0;
    endtask

    initial begin
        logic prev;

        b.en = '0; b.mode = '0; b.sync = 1'b0; b.wr_en = 1'b0; b.wr_ch = '0; b.wr_data = '0;
        bd.en = '0; bd.mode = '0; bd.sync = 1'b0; bd.wr_en = 1'b0; bd.wr_ch = '0; bd.wr_data = '0;
        model_reset();

        // Reset state and default reload read-back.
        #12;
        chk("rst_clk_out", 64'(b.clk_out), 64'd0);
        chk("rst_tick",    64'(b.tick),    64'd0);
        for (int c = 0; c < CH; c++) begin
            b.wr_ch  = 4'(c);
            bd.wr_ch = 4'(c);
            #1;
            chk("rst_rd_small", 64'(b.rd_data),  64'(DEF));
            chk("rst_rd_big",   64'(bd.rd_data), 64'(DEF_BIG));
        end
        b.wr_ch = '0;

        // Free-running square mode from reset: first toggle after DEF+1 cycles.
        b.en = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 2 * (DEF + 1); k++) begin
            cyc();
            if (k == DEF)           chk("def_before", 64'(b.clk_out), 64'h0);
            if (k == DEF + 1)       chk("def_first",  64'(b.clk_out), 64'hF);
            if (k == 2 * DEF + 1)   chk("def_hold",   64'(b.clk_out), 64'hF);
            if (k == 2 * (DEF + 1)) chk("def_second", 64'(b.clk_out), 64'h0);
        end

        // Ch1 tick mode with reload 3: pulses on cycles 4, 8, 12 after sync.
        wr(1, 3);
        b.en = 4'b0010; b.mode = 4'b0010;
        do_sync();
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("ch1_tick", 64'(b.tick[1]), 64'((k % 4) == 0));
            chk("ch1_clk",  64'(b.clk_out[1]), 64'd0);
        end

        // Ch2 reload 0: clk/2 in square mode, constant tick in tick mode.
        wr(2, 0);
        b.en = 4'b0100; b.mode = 4'b0000;
        do_sync();
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("ch2_half", 64'(b.clk_out[2]), 64'(k % 2));
        end
        b.mode = 4'b0100;
        do_sync();
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("ch2_tick", 64'(b.tick[2]), 64'd1);
        end

        // Ch0 reload 9: write 2 while counting, then write 9 on an event edge.
        wr(0, 9);
        b.en = 4'b0001; b.mode = 4'b0000;
        do_sync();
        prev = b.clk_out[0];
        for (int k = 1; k <= 33; k++) begin
            b.wr_en = (k == 5) || (k == 19);
            b.wr_ch = 4'd0;
            b.wr_data = (k == 5) ? CW'(2) : CW'(9);
            cyc();
            chk("ch0_evt", 64'(b.clk_out[0] ^ prev),
                64'(k == 10 || k == 13 || k == 16 || k == 19 || k == 22 || k == 32));
            prev = b.clk_out[0];
        end
        b.wr_en = 1'b0;

        // Ch3 reload 4: pause at count 2, resume, event 3 cycles later.
        wr(3, 4);
        b.en = 4'b1000; b.mode = 4'b0000;
        do_sync();
        cyc();
        cyc();
        prev = b.clk_out[3];
        b.en = 4'b0000;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            chk("ch3_frozen", 64'(b.clk_out[3]), 64'(prev));
        end
        b.en = 4'b1000;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk("ch3_resume", 64'(b.clk_out[3] ^ prev), 64'(k == 3));
            prev = b.clk_out[3];
        end

        // Randomized traffic, including sync/write collisions and bad indices.
        for (int k = 0; k < 400; k++) begin
            b.en      = 4'($urandom);
            b.mode    = 4'($urandom);
            b.sync    = ($urandom_range(0, 19) == 0);
            b.wr_en   = ($urandom_range(0, 3) == 0);
            b.wr_ch   = 4'($urandom_range(0, 7));
            b.wr_data = CW'($urandom_range(0, 5));
            cyc();
        end
        b.sync = 1'b0; b.wr_en = 1'b0;

        // Get ch2 toggling every cycle, then assert reset between edges.
        wr(2, 0);
        b.en = 4'hF; b.mode = 4'h0;
        do_sync();
        cyc();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_clk_out", 64'(b.clk_out), 64'd0);
        chk("arst_tick",    64'(b.tick),    64'd0);
        model_reset();
        for (int c = 0; c < CH; c++) begin
            b.wr_ch  = 4'(c);
            bd.wr_ch = 4'(c);
            #1;
            chk("arst_rd_small", 64'(b.rd_data),  64'(DEF));
            chk("arst_rd_big",   64'(bd.rd_data), 64'(DEF_BIG));
        end
        @(posedge clk);
        #1;
        chk("arst_hold", 64'(b.clk_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Write to non-existent channel 5 is dropped and reads back 0.
        b.wr_en = 1'b1; b.wr_ch = 4'd5; b.wr_data = CW'(7);
        cyc();
        b.wr_en = 1'b0;
        chk("bad_ch_rd", 64'(b.rd_data), 64'd0);
        for (int c = 0; c < CH; c++) begin
            b.wr_ch = 4'(c);
            #1;
            chk("bad_ch_keep", 64'(b.rd_data), 64'(DEF));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
